reg_exec_ctrl: RTL and testbench
================================

Name: reg_exec_ctrl

Overview:
- Single-issue execute/write-back sequencer that sits around the 8-entry x 8-bit register bank.
- Accepts one instruction per handshake and drives the bank read ports (ra1/ra2).
- Captures rd1/rd2, computes an ALU result, then writes it back through wa3/wd3/we3.
- Ports connect one-to-one to the register bank; no glue logic.

Parameters:
- DW, 8, data width (matches register bank data).
- AW, 3, register address width (2^AW registers).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  block can accept an instruction.
- instr_op  in  3  opcode (see Behaviour).
- instr_rd  in  AW  destination register.
- instr_rs1  in  AW  source register A.
- instr_rs2  in  AW  source register B.
- instr_imm  in  DW  immediate for LDI.
- ra1  out  AW  bank read address 1.
- ra2  out  AW  bank read address 2.
- rd1  in  DW  bank read data 1 (combinational from ra1).
- rd2  in  DW  bank read data 2 (combinational from ra2).
- wa3  out  AW  bank write address.
- wd3  out  DW  bank write data.
- we3  out  1  bank write enable.
- zero  out  1  result == 0, from the last executed op.
- carry  out  1  carry/borrow, from the last executed op.
- done  out  1  one-cycle pulse, instruction retired.

Behaviour:
- Reset (reset==0 at a rising edge), all outputs:
  - state=IDLE, instr_ready=1 (combinational from state).
  - ra1=ra2=wa3=0, wd3=0, we3=0.
  - zero=0, carry=0, done=0.
  - Latched instruction fields cleared.
- Reset during any state aborts the instruction; no write reaches the bank.
- FSM states IDLE, READ, EXEC, WB.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready at edge E0, latch op/rd/rs1/rs2/imm and go to READ.
- READ (cycle after E0):
  - ra1=rs1_q, ra2=rs2_q (combinational from latched fields).
  - At edge E1, capture rd1->op_a, rd2->op_b; go to EXEC.
- EXEC:
  - At edge E2, register result[DW-1:0], zero and carry; go to WB.
- WB:
  - If op!=CMP: we3=1, wa3=rd_q, wd3=result.
  - done=1 for exactly this cycle, including for CMP.
  - Bank writes at edge E3; go to IDLE.
- Outside WB: we3=0, wa3=0, wd3=0, done=0.
- Outside READ: ra1=ra2=0.
- instr_ready=0 from E0 through E3. Throughput is one instruction per 4 cycles; accept-to-write latency is 3 edges.
- Back-to-back: a new instruction can be accepted at the first edge after returning to IDLE. Its READ follows the previous write, so there are no RAW hazards.
- Opcodes; arithmetic is on DW+1 bits, result truncated to DW:
  - 0 ADD: a+b, carry=bit DW.
  - 1 SUB: a-b, carry=borrow (a<b unsigned).
  - 2 AND, 3 OR, 4 XOR: carry=0.
  - 5 MOV: result=a, carry=0.
  - 6 LDI: result=imm, carry=0. Read ports still driven, operands ignored.
  - 7 CMP: as SUB, flags only, we3 stays 0.
- zero and carry hold between instructions; they update only at E2.
- rd_q == rs1_q is legal: source is read before write.

Decomposition:
- Package reg_exec_pkg holds:
  - DW/AW localparam defaults.
  - typedef enum logic[2:0] op_e {ADD,SUB,AND,OR,XOR,MOV,LDI,CMP}.
  - typedef enum logic[1:0] state_e {IDLE,READ,EXEC,WB}.
- Sub-module alu_core: combinational; inputs op, a, b, imm; outputs result, carry, zero.
- Top holds the FSM, the latches and the port muxing.

Test Plan:
- Reset low for 1 clk, then high -> instr_ready=1, we3=0, zero=0, carry=0, all addresses 0.
- Bank preloaded r1=10, r2=20; ADD rd=3 rs1=1 rs2=2 -> READ cycle ra1=1/ra2=2; on the 4th cycle after accept we3=1, wa3=3, wd3=30, done=1; carry=0, zero=0.
- SUB rd=4 rs1=1 rs2=2 -> wd3=246, carry=1. Then CMP rs1=1 rs2=1 -> zero=1, carry=0, we3 never high, done pulses once, r4 still 246.
- LDI rd=5 imm=255, then ADD rd=6 rs1=5 rs2=7 (r7=1) -> wd3=0, zero=1, carry=1.
- instr_valid held high with two instructions -> instr_ready low for exactly 3 cycles; second instruction accepted on the 4th edge; writes are 4 cycles apart.
- Reset driven low in EXEC of ADD rd=2 -> we3 stays 0, r2 unchanged, instr_ready=1 the next cycle, flags 0.

Source files
------------

// File: rtl/reg_exec_pkg.sv
// Shared types and default widths for the register-bank execute sequencer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package reg_exec_pkg;

    localparam int DW_DEFAULT = 8;
    localparam int AW_DEFAULT = 3;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        AND = 3'd2,
        OR  = 3'd3,
        XOR = 3'd4,
        MOV = 3'd5,
        LDI = 3'd6,
        CMP = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_e;

endpackage

// File: rtl/reg_exec_ctrl_alu_core.sv
// Combinational ALU: result, carry/borrow and zero for one latched instruction.
// Latency: zero cycles, purely combinational.
// Backpressure: none; the caller decides when to register the outputs.
module alu_core
    import reg_exec_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  op_e           op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] imm,
    output logic [DW-1:0] result,
    output logic          carry,
    output logic          zero
);

    logic [DW:0] wide;

    // Arithmetic on DW+1 bits so the top bit is the carry (ADD) or borrow (SUB/CMP).
    always_comb begin
        wide   = '0;
        result = '0;
        carry  = 1'b0;
        case (op)
            ADD: begin
                wide   = {1'b0, a} + {1'b0, b};
                result = wide[DW-1:0];
                carry  = wide[DW];
            end
            SUB, CMP: begin
                wide   = {1'b0, a} - {1'b0, b};
                result = wide[DW-1:0];
                carry  = wide[DW];
            end
            AND:     result = a & b;
            OR:      result = a | b;
            XOR:     result = a ^ b;
            MOV:     result = a;
            LDI:     result = imm;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/reg_exec_ctrl.sv
// Single-issue read/execute/write-back sequencer driving an 8x8 register bank.
// Latency: accept at E0, bank write at E3 (3 edges); one instruction per 4 cycles.
// Backpressure: instr_ready is high only in IDLE; held low from accept through write-back.
module reg_exec_ctrl
    import reg_exec_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int AW = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [2:0]    instr_op,
    input  logic [AW-1:0] instr_rd,
    input  logic [AW-1:0] instr_rs1,
    input  logic [AW-1:0] instr_rs2,
    input  logic [DW-1:0] instr_imm,
    output logic [AW-1:0] ra1,
    output logic [AW-1:0] ra2,
    input  logic [DW-1:0] rd1,
    input  logic [DW-1:0] rd2,
    output logic [AW-1:0] wa3,
    output logic [DW-1:0] wd3,
    output logic          we3,
    output logic          zero,
    output logic          carry,
    output logic          done
);

    state_e        state_q, state_d;
    op_e           op_q, op_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] rs1_q, rs1_d;
    logic [AW-1:0] rs2_q, rs2_d;
    logic [DW-1:0] imm_q, imm_d;
    logic [DW-1:0] op_a_q, op_a_d;
    logic [DW-1:0] op_b_q, op_b_d;
    logic [DW-1:0] result_q, result_d;
    logic          zero_q, zero_d;
    logic          carry_q, carry_d;

    logic [DW-1:0] alu_result;
    logic          alu_carry;
    logic          alu_zero;

    alu_core #(.DW(DW)) u_alu (
        .op     (op_q),
        .a      (op_a_q),
        .b      (op_b_q),
        .imm    (imm_q),
        .result (alu_result),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

    // State register and pipeline latches; synchronous active-low reset aborts any instruction.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            op_q     <= ADD;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            imm_q    <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            imm_q    <= imm_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
        end
    end

    // Next state plus latch updates: fields at accept, operands in READ, result/flags in EXEC.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        imm_d    = imm_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    op_d    = op_e'(instr_op);
                    rd_d    = instr_rd;
                    rs1_d   = instr_rs1;
                    rs2_d   = instr_rs2;
                    imm_d   = instr_imm;
                    state_d = READ;
                end
            end
            READ: begin
                op_a_d  = rd1;
                op_b_d  = rd2;
                state_d = EXEC;
            end
            EXEC: begin
                result_d = alu_result;
                zero_d   = alu_zero;
                carry_d  = alu_carry;
                state_d  = WB;
            end
            WB: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Port muxing: bank addresses only in READ, write strobe and retire pulse only in WB.
    always_comb begin
        instr_ready = (state_q == IDLE);
        ra1         = '0;
        ra2         = '0;
        wa3         = '0;
        wd3         = '0;
        we3         = 1'b0;
        done        = 1'b0;
        case (state_q)
            READ: begin
                ra1 = rs1_q;
                ra2 = rs2_q;
            end
            WB: begin
                done = 1'b1;
                if (op_q != CMP) begin
                    we3 = 1'b1;
                    wa3 = rd_q;
                    wd3 = result_q;
                end
            end
            default: ;
        endcase
    end

    assign zero  = zero_q;
    assign carry = carry_q;

endmodule

// File: tb/tb_reg_exec_ctrl.sv
// Bench for reg_exec_ctrl with a behavioural register bank and an arithmetic reference model.
// Latency: checks each instruction at READ, EXEC, WB and the following IDLE cycle.
// Backpressure: waits on instr_ready with a bounded cycle budget.
module tb_reg_exec_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [2:0] instr_op = 3'd0;
    logic [2:0] instr_rd = 3'd0;
    logic [2:0] instr_rs1 = 3'd0;
    logic [2:0] instr_rs2 = 3'd0;
    logic [7:0] instr_imm = 8'd0;
    logic [2:0] ra1, ra2, wa3;
    logic [7:0] rd1, rd2, wd3;
    logic       we3, zero, carry, done;

    logic [7:0] bank [8];
    int         cyc = 0;
    int         nwrites = 0;
    int         wr_cyc [$];

    int         vectors = 0;
    int         miscompares = 0;

    logic [7:0] ref_mem [8];
    logic       ref_zero = 1'b0;
    logic       ref_carry = 1'b0;

    always #5 clk = ~clk;

    reg_exec_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_rd    (instr_rd),
        .instr_rs1   (instr_rs1),
        .instr_rs2   (instr_rs2),
        .instr_imm   (instr_imm),
        .ra1         (ra1),
        .ra2         (ra2),
        .rd1         (rd1),
        .rd2         (rd2),
        .wa3         (wa3),
        .wd3         (wd3),
        .we3         (we3),
        .zero        (zero),
        .carry       (carry),
        .done        (done)
    );

    // Register bank: combinational reads, write on the rising edge.
    assign rd1 = bank[ra1];
    assign rd2 = bank[ra2];

    always @(posedge clk) begin
        if (we3) begin
            bank[wa3] <= wd3;
            nwrites = nwrites + 1;
            wr_cyc.push_back(cyc);
        end
        cyc = cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: integer arithmetic straight from the opcode table.
    function automatic void model(input int op, input int a, input int b, input int imm,
                                  output int res, output logic c, output logic z, output logic w);
        int s;
        c = 1'b0;
        w = (op != 7);
        case (op)
            0: begin s = a + b; res = s % 256; c = (s > 255); end
            1, 7: begin res = (a - b + 256) % 256; c = (a < b); end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: res = a;
            6: res = imm;
            default: res = 0;
        endcase
        z = (res == 0);
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (instr_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("ready_timeout", 32'(instr_ready), 32'd1);
    endtask

    // Issue one instruction and check every phase against the model. Called at a negedge.
    task automatic issue(input int op, input int rd, input int rs1, input int rs2, input int imm);
        int   res;
        logic c, z, w;
        model(op, int'(ref_mem[rs1]), int'(ref_mem[rs2]), imm, res, c, z, w);
        wait_ready();
        instr_valid = 1'b1;
        instr_op    = 3'(op);
        instr_rd    = 3'(rd);
        instr_rs1   = 3'(rs1);
        instr_rs2   = 3'(rs2);
        instr_imm   = 8'(imm);
        @(negedge clk);
        instr_valid = 1'b0;
        chk("ready_in_read", 32'(instr_ready), 32'd0);
        chk("ra1_read", 32'(ra1), 32'(rs1));
        chk("ra2_read", 32'(ra2), 32'(rs2));
        @(negedge clk);
        chk("we3_exec", 32'(we3), 32'd0);
        chk("done_exec", 32'(done), 32'd0);
        @(negedge clk);
        chk("done_wb", 32'(done), 32'd1);
        chk("we3_wb", 32'(we3), 32'(w));
        chk("wa3_wb", 32'(wa3), w ? 32'(rd) : 32'd0);
        chk("wd3_wb", 32'(wd3), w ? 32'(res) : 32'd0);
        chk("zero_wb", 32'(zero), 32'(z));
        chk("carry_wb", 32'(carry), 32'(c));
        if (w) ref_mem[rd] = 8'(res);
        ref_zero  = z;
        ref_carry = c;
        @(negedge clk);
        chk("ready_idle", 32'(instr_ready), 32'd1);
        chk("done_idle", 32'(done), 32'd0);
        chk("bank_after", 32'(bank[rd]), 32'(ref_mem[rd]));
    endtask

    initial begin
        int   res_a, res_b, low, nw;
        logic ca, za, wa, cb, zb, wb;

        // Reset for one clock, then release.
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_we3", 32'(we3), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_carry", 32'(carry), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ra1", 32'(ra1), 32'd0);
        chk("rst_ra2", 32'(ra2), 32'd0);
        chk("rst_wa3", 32'(wa3), 32'd0);
        chk("rst_wd3", 32'(wd3), 32'd0);

        // Preload every register through LDI.
        for (int r = 0; r < 8; r++) begin
            int v;
            v = (r == 1) ? 10 : (r == 2) ? 20 : (r == 7) ? 1 : int'($urandom_range(0, 255));
            issue(6, r, r, 7 - r, v);
        end

        // Directed cases.
        issue(0, 3, 1, 2, 0);
        chk("add_r3", 32'(bank[3]), 32'd30);
        issue(1, 4, 1, 2, 0);
        chk("sub_r4", 32'(bank[4]), 32'd246);
        chk("sub_carry", 32'(carry), 32'd1);
        nw = nwrites;
        issue(7, 4, 1, 1, 0);
        chk("cmp_zero", 32'(zero), 32'd1);
        chk("cmp_carry", 32'(carry), 32'd0);
        chk("cmp_no_write", 32'(nwrites), 32'(nw));
        chk("cmp_r4_kept", 32'(bank[4]), 32'd246);
        issue(6, 5, 0, 0, 255);
        issue(0, 6, 5, 7, 0);
        chk("wrap_r6", 32'(bank[6]), 32'd0);
        chk("wrap_zero", 32'(zero), 32'd1);
        chk("wrap_carry", 32'(carry), 32'd1);

        // Reset asserted during EXEC of ADD rd=2: no write, flags cleared.
        wait_ready();
        instr_valid = 1'b1;
        instr_op = 3'd0; instr_rd = 3'd2; instr_rs1 = 3'd1; instr_rs2 = 3'd1; instr_imm = 8'd0;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        nw = nwrites;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("abort_ready", 32'(instr_ready), 32'd1);
        chk("abort_we3", 32'(we3), 32'd0);
        chk("abort_zero", 32'(zero), 32'd0);
        chk("abort_carry", 32'(carry), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("abort_no_write", 32'(nwrites), 32'(nw));
        chk("abort_r2", 32'(bank[2]), 32'(ref_mem[2]));
        ref_zero  = 1'b0;
        ref_carry = 1'b0;

        // Back-to-back: valid held high across two instructions; B reads A's result.
        wait_ready();
        model(0, int'(ref_mem[1]), int'(ref_mem[2]), 0, res_a, ca, za, wa);
        instr_valid = 1'b1;
        instr_op = 3'd0; instr_rd = 3'd0; instr_rs1 = 3'd1; instr_rs2 = 3'd2; instr_imm = 8'd0;
        @(negedge clk);
        ref_mem[0] = 8'(res_a);
        model(1, int'(ref_mem[0]), int'(ref_mem[2]), 0, res_b, cb, zb, wb);
        instr_op = 3'd1; instr_rd = 3'd3; instr_rs1 = 3'd0; instr_rs2 = 3'd2;
        low = 0;
        while (instr_ready !== 1'b1 && low < 10) begin
            low++;
            @(negedge clk);
        end
        chk("b2b_busy_cycles", 32'(low), 32'd3);
        @(negedge clk);
        instr_valid = 1'b0;
        chk("b2b_accept", 32'(instr_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        ref_mem[3] = 8'(res_b);
        ref_zero   = zb;
        ref_carry  = cb;
        chk("b2b_r0", 32'(bank[0]), 32'(ref_mem[0]));
        chk("b2b_r3", 32'(bank[3]), 32'(ref_mem[3]));
        chk("b2b_zero", 32'(zero), 32'(ref_zero));
        chk("b2b_carry", 32'(carry), 32'(ref_carry));
        if (wr_cyc.size() >= 2)
            chk("b2b_write_gap", 32'(wr_cyc[wr_cyc.size()-1] - wr_cyc[wr_cyc.size()-2]), 32'd4);
        else
            chk("b2b_write_count", 32'(wr_cyc.size()), 32'd2);

        // Randomized instructions against the model.
        for (int i = 0; i < 40; i++) begin
            issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 255)));
        end

        // Final bank sweep against the model.
        for (int r = 0; r < 8; r++) chk("final_bank", 32'(bank[r]), 32'(ref_mem[r]));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
